// File: rtl/count_uart_pkg.sv
// count_uart_pkg: shared FSM states, ASCII constants and frame helpers (ASCII mode selected by COUNT_UART_ASCII_EN)
package count_uart_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, NEXT_BYTE} state_e;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
`ifdef COUNT_UART_ASCII_EN
  localparam bit ASCII_EN = 1'b1;
`else
  localparam bit ASCII_EN = 1'b0;
`endif
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  function automatic int frame_len(input int count_w, input bit ascii);
    return ascii ? count_w / 4 + 2 : count_w / 8;
  endfunction
endpackage

// File: rtl/count_byte_select.sv
// count_byte_select: maps snapshot and byte index to the outgoing byte, MSB first (hex text plus CR/LF under COUNT_UART_ASCII_EN)
module count_byte_select
  import count_uart_pkg::*;
#(
  parameter int COUNT_W = 32,
  parameter int IDX_W = 4
) (
  input  logic [COUNT_W-1:0] snap,
  input  logic [IDX_W-1:0]   idx,
  output logic [7:0]         data
);
`ifdef COUNT_UART_ASCII_EN
  localparam int NIBS = COUNT_W / 4;
  logic [3:0] nib;
  // nibble idx counted from the MSB, terminator bytes after the last nibble
  always_comb begin
    nib = 4'((snap << {idx, 2'b00}) >> (COUNT_W - 4));
    data = idx == IDX_W'(NIBS) ? ASCII_CR : idx == IDX_W'(NIBS + 1) ? ASCII_LF : hex_to_ascii(nib);
  end
`else
  assign data = 8'((snap << {idx, 3'b000}) >> (COUNT_W - 8));
`endif
endmodule

// File: rtl/count_uart_scheduler.sv
// count_uart_scheduler: snapshots the count on request and feeds it byte by byte into the UART (ASCII mode via COUNT_UART_ASCII_EN)
module count_uart_scheduler
  import count_uart_pkg::*;
#(
  parameter int COUNT_W = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [COUNT_W-1:0] i_count,
  input  logic               i_send,
  input  logic               i_tx_busy,
  output logic               o_start_transmission,
  output logic [7:0]         o_tx_data,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_ack_error
);
  localparam int FLEN = frame_len(COUNT_W, ASCII_EN);
  localparam int IDX_W = $clog2(FLEN + 1);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [COUNT_W-1:0] snap_q, next_q;
  logic [IDX_W-1:0] idx_q, sel_idx;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0] sel_byte;
  logic pend_q, start_d, abort, last, reload;
  assign o_busy = state_q != IDLE;
  assign last = idx_q == IDX_W'(FLEN - 1);
  assign reload = state_q == NEXT_BYTE && last && (pend_q || i_send);
  assign sel_idx = state_q == LOAD ? '0 : idx_q + 1'b1;
  count_byte_select #(.COUNT_W(COUNT_W), .IDX_W(IDX_W)) u_sel (
    .snap(snap_q),
    .idx (sel_idx),
    .data(sel_byte)
  );
  // next state, start request and ack-timeout abort
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    abort = 1'b0;
    case (state_q)
      IDLE:      state_d = i_send ? LOAD : IDLE;
      LOAD:      state_d = START;
      START: begin
        start_d = !i_tx_busy;
        state_d = i_tx_busy ? START : WAIT_ACK;
      end
      WAIT_ACK: begin
        abort = !i_tx_busy && tmo_q == TMO_W'(ACK_TIMEOUT - 1);
        state_d = i_tx_busy ? WAIT_DONE : abort ? IDLE : WAIT_ACK;
      end
      WAIT_DONE: state_d = i_tx_busy ? WAIT_DONE : NEXT_BYTE;
      NEXT_BYTE: state_d = !last ? START : reload ? LOAD : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // snapshot, one-deep pending request, byte index and handshake outputs
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      snap_q <= '0;
      next_q <= '0;
      pend_q <= 1'b0;
      idx_q <= '0;
      tmo_q <= '0;
      o_tx_data <= '0;
      o_start_transmission <= 1'b0;
      o_overrun <= 1'b0;
      o_ack_error <= 1'b0;
    end else begin
      o_start_transmission <= start_d;
      o_overrun <= (pend_q && (i_send || abort)) || (abort && i_send);
      o_ack_error <= o_ack_error || abort;
      tmo_q <= state_q == WAIT_ACK ? tmo_q + 1'b1 : '0;
      pend_q <= !(reload || abort) && (pend_q || (o_busy && i_send));
      if (o_busy && i_send) next_q <= i_count;
      if (state_q == IDLE && i_send) snap_q <= i_count;
      if (reload) snap_q <= i_send ? i_count : next_q;
      if (state_q == LOAD || (state_q == NEXT_BYTE && !last)) begin
        idx_q <= sel_idx;
        o_tx_data <= sel_byte;
      end
    end
  end
endmodule
